// File: rtl/sad_pkg.sv
// Shared sizing and FSM encoding for the block SAD controller and its datapath stage.
package sad_pkg;

  localparam int PIXEL_W   = 8;
  localparam int BLOCK_LEN = 16;
  localparam int ADDR_W    = $clog2(BLOCK_LEN);
  localparam int SUM_W     = PIXEL_W + ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sad_state_t;

endpackage

// File: rtl/sad_absdiff_stage.sv
// Registered |a-b| of one pixel pair; data only loads on a valid pair so idle-bus
// values on the pixel inputs never reach the accumulator.
module sad_absdiff_stage #(
  parameter int PIXEL_W = sad_pkg::PIXEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [PIXEL_W-1:0] i_pix_a,
  input  logic [PIXEL_W-1:0] i_pix_b,
  output logic               o_valid,
  output logic [PIXEL_W-1:0] o_diff
);
  import sad_pkg::*;

  logic signed [PIXEL_W:0] w_delta;
  logic        [PIXEL_W:0] w_mag;
  logic                    r_valid;
  logic        [PIXEL_W-1:0] r_diff;

  // Signed difference with one guard bit, then magnitude; |a-b| always fits PIXEL_W bits.
  always_comb begin
    w_delta = $signed({1'b0, i_pix_a}) - $signed({1'b0, i_pix_b});
    if (w_delta[PIXEL_W]) begin
      w_mag = -w_delta;
    end else begin
      w_mag = w_delta;
    end
  end

  // Diff register and its valid flag; flush drops an in-flight pair on abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_diff  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_diff <= w_mag[PIXEL_W-1:0];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_diff  = r_diff;

endmodule

// File: rtl/sad_block_ctrl.sv
// Block SAD sequencer: drives the shared pixel-RAM read port, accumulates |a-b|
// over one block and publishes the total with a start/done handshake.
module sad_block_ctrl #(
  parameter int PIXEL_W   = sad_pkg::PIXEL_W,
  parameter int BLOCK_LEN = sad_pkg::BLOCK_LEN,
  parameter int ADDR_W    = sad_pkg::ADDR_W,
  parameter int SUM_W     = sad_pkg::SUM_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_addr,
  input  logic [PIXEL_W-1:0] i_pix_a,
  input  logic [PIXEL_W-1:0] i_pix_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [SUM_W-1:0]   o_sad
);
  import sad_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_LEN - 1);

  sad_state_t         r_state;
  sad_state_t         w_next_state;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_drain_cnt;
  logic               r_rd_en;
  logic               r_busy;
  logic               r_done;
  logic               r_pix_vld;
  logic [SUM_W-1:0]   r_acc;
  logic [SUM_W-1:0]   r_sad;
  logic [SUM_W-1:0]   w_acc_next;
  logic               w_run;
  logic               w_flush;
  logic               w_enter_fetch;
  logic               w_finish;
  logic               w_diff_vld;
  logic [PIXEL_W-1:0] w_diff;

  assign w_run         = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_flush       = w_run && i_abort;
  assign w_enter_fetch = (w_next_state == S_FETCH) && (r_state != S_FETCH);
  assign w_finish      = (r_state == S_DRAIN) && (w_next_state == S_DONE);

  // Next-state logic; abort beats start, and a start in DONE chains straight into FETCH.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (i_start) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FETCH: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_addr == LAST_ADDR) begin
          w_next_state = S_DRAIN;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (r_drain_cnt) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_DRAIN;
        end
      end
      S_DONE: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (i_start) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register plus the strobes decoded one cycle early so they leave a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_rd_en <= (w_next_state == S_FETCH);
      r_busy  <= (w_next_state == S_FETCH) || (w_next_state == S_DRAIN);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Address counter; it stops on the last address and holds outside FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_enter_fetch) begin
      r_addr <= '0;
    end else if ((r_state == S_FETCH) && (w_next_state == S_FETCH)) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else begin
      r_addr <= r_addr;
    end
  end

  // Two DRAIN cycles let the last pair pass the diff and accumulate stages.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drain_cnt <= 1'b0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= 1'b1;
    end else begin
      r_drain_cnt <= 1'b0;
    end
  end

  // Pixel-valid flag: RAM data lands one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pix_vld <= 1'b0;
    end else if (w_flush) begin
      r_pix_vld <= 1'b0;
    end else begin
      r_pix_vld <= r_rd_en;
    end
  end

  sad_absdiff_stage #(
    .PIXEL_W (PIXEL_W)
  ) u_absdiff (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_valid (r_pix_vld),
    .i_pix_a (i_pix_a),
    .i_pix_b (i_pix_b),
    .o_valid (w_diff_vld),
    .o_diff  (w_diff)
  );

  // Running sum including the diff landing this cycle; SUM_W holds the worst case.
  always_comb begin
    if (w_diff_vld) begin
      w_acc_next = r_acc + SUM_W'(w_diff);
    end else begin
      w_acc_next = r_acc;
    end
  end

  // Accumulator clears on every entry to FETCH so each block starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_enter_fetch) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_next;
    end
  end

  // Result register captures the final sum so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sad <= '0;
    end else if (w_finish) begin
      r_sad <= w_acc_next;
    end else begin
      r_sad <= r_sad;
    end
  end

  assign o_rd_en = r_rd_en;
  assign o_addr  = r_addr;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_sad   = r_sad;

endmodule

// File: tb/tb_sad_block_ctrl.sv
// Self-checking bench for sad_block_ctrl: 1-cycle RAM model, directed and random
// pixel blocks, protocol corner cases, checked against a plain-arithmetic SAD model.
module tb_sad_block_ctrl;
  import sad_pkg::*;

  localparam int LAT = BLOCK_LEN + 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_start;
  logic               i_abort;
  logic               o_rd_en;
  logic [ADDR_W-1:0]  o_addr;
  logic [PIXEL_W-1:0] i_pix_a;
  logic [PIXEL_W-1:0] i_pix_b;
  logic               o_busy;
  logic               o_done;
  logic [SUM_W-1:0]   o_sad;

  logic [PIXEL_W-1:0] mem_a [BLOCK_LEN];
  logic [PIXEL_W-1:0] mem_b [BLOCK_LEN];
  int n_chk  = 0;
  int n_pass = 0;
  int exp_hold = 0;
  int exp_sad;
  int exp_sad2;

  always #5 clk = ~clk;

  sad_block_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_abort (i_abort),
    .o_rd_en (o_rd_en),
    .o_addr  (o_addr),
    .i_pix_a (i_pix_a),
    .i_pix_b (i_pix_b),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_sad   (o_sad)
  );

  // Synchronous RAMs: data follows a read by one cycle; junk on the bus otherwise.
  always @(posedge clk) begin
    if (o_rd_en) begin
      i_pix_a <= mem_a[o_addr];
      i_pix_b <= mem_b[o_addr];
    end else begin
      i_pix_a <= PIXEL_W'($urandom);
      i_pix_b <= PIXEL_W'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_sad();
    int s = 0;
    for (int i = 0; i < BLOCK_LEN; i++) begin
      int a = int'(mem_a[i]);
      int b = int'(mem_b[i]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < BLOCK_LEN; i++) begin
      case (mode)
        0: begin mem_a[i] = 8'd25;  mem_b[i] = 8'd0;  end
        1: begin mem_a[i] = 8'd0;   mem_b[i] = 8'd25; end
        2: begin mem_a[i] = 8'd77;  mem_b[i] = 8'd77; end
        3: begin mem_a[i] = 8'd255; mem_b[i] = 8'd0;  end
        4: begin mem_a[i] = PIXEL_W'(i); mem_b[i] = PIXEL_W'(BLOCK_LEN - 1 - i); end
        default: begin mem_a[i] = PIXEL_W'($urandom); mem_b[i] = PIXEL_W'($urandom); end
      endcase
    end
  endtask

  // Caller has i_start=1 during cycle 0; walks cycles 1..LAT checking the handshake.
  task automatic run_block(input int exp_v, input bit noise, input bit chain);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      check_eq("busy", o_busy, (c <= LAT - 1));
      check_eq("rd_en", o_rd_en, (c <= BLOCK_LEN));
      check_eq("done", o_done, (c == LAT));
      if (c <= BLOCK_LEN) check_eq("addr", o_addr, c - 1);
      if (c == LAT) check_eq("sad", o_sad, exp_v);
      else check_eq("sad_hold", o_sad, exp_hold);
      i_start = (noise && (c == 5 || c == 10)) || (chain && c == LAT);
    end
    exp_hold = exp_v;
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rd_en", o_rd_en, 0);
    check_eq("rst_addr", o_addr, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_sad", o_sad, 0);
    rst_n = 1'b1;

    // Directed fills; the first also throws ignored starts at cycles 5 and 10.
    for (int m = 0; m < 5; m++) begin
      @(negedge clk);
      fill(m); exp_sad = ref_sad();
      i_start = 1'b1;
      run_block(exp_sad, (m == 0), 1'b0);
    end

    // Start in the done cycle chains a second block (done at cycle 38).
    @(negedge clk);
    fill(9); exp_sad = ref_sad();
    i_start = 1'b1;
    run_block(exp_sad, 1'b0, 1'b1);
    fill(9); exp_sad2 = ref_sad();
    run_block(exp_sad2, 1'b0, 1'b0);

    // Abort at cycle 8 after a result of 400.
    @(negedge clk);
    fill(0); exp_sad = ref_sad();
    i_start = 1'b1;
    run_block(exp_sad, 1'b0, 1'b0);
    @(negedge clk);
    fill(9);
    i_start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_abort = (c == 8);
    end
    @(negedge clk);
    i_abort = 1'b0;
    check_eq("abort_busy", o_busy, 0);
    check_eq("abort_rd_en", o_rd_en, 0);
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      check_eq("abort_no_done", o_done, 0);
      check_eq("abort_sad_hold", o_sad, exp_hold);
    end
    exp_sad = ref_sad();
    i_start = 1'b1;
    run_block(exp_sad, 1'b0, 1'b0);

    // Abort together with start in IDLE drops the start.
    @(negedge clk);
    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    check_eq("abort_start_busy", o_busy, 0);
    @(negedge clk);
    check_eq("abort_start_busy2", o_busy, 0);
    check_eq("abort_start_rd", o_rd_en, 0);

    // Reset at cycle 10 of a run.
    @(negedge clk);
    fill(9);
    i_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      rst_n = (c != 10);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mrst_rd_en", o_rd_en, 0);
    check_eq("mrst_addr", o_addr, 0);
    check_eq("mrst_busy", o_busy, 0);
    check_eq("mrst_done", o_done, 0);
    check_eq("mrst_sad", o_sad, 0);
    check_eq("mrst_state", dut.r_state, 0);
    exp_hold = 0;

    // Random blocks after reset.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      fill(9); exp_sad = ref_sad();
      i_start = 1'b1;
      run_block(exp_sad, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
